emesh_stim_arbiter: RTL and testbench

- Round-robin arbiter with burst hold that shares one emesh packet input (dut access_in/packet_in/wait_out) among N stimulus sources, such as multiple drivers or a driver plus a monitor loopback.
- Sits between the stimulus drivers and the dut in the dv top, or ahead of any single-port emesh sink.
- Registered single-entry output stage that honours emesh wait backpressure.
- Per-source wait tells each losing or blocked source to hold its packet.

---
 rtl/emesh_arb_pkg.sv | 12 +
 rtl/emesh_rr_pick.sv | 31 +++
 rtl/emesh_stim_arbiter.sv | 98 +++++++++
 tb/tb_emesh_stim_arbiter.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/emesh_arb_pkg.sv
// Shared defaults and the emesh packet-width helper for the stimulus arbiter.
package emesh_arb_pkg;

  localparam int N_DEF     = 4;
  localparam int AW_DEF    = 32;
  localparam int BURST_DEF = 2;

  function automatic int pw(input int aw);
    return 2 * aw + 40;
  endfunction

endpackage

// File: rtl/emesh_rr_pick.sv
// Combinational round-robin picker: first set request at or after start, wrapping mod N.
module emesh_rr_pick
  import emesh_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int SW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] start,
  output logic          gnt_valid,
  output logic [SW-1:0] gnt
);

  int idx;

  // Scan from the farthest offset down so the nearest request is written last and wins.
  always_comb begin
    gnt_valid = 1'b0;
    gnt       = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = int'(start) + k;
      if (idx >= N) idx = idx - N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt       = SW'(idx);
      end
    end
  end

endmodule

// File: rtl/emesh_stim_arbiter.sv
// Round-robin arbiter with burst hold sharing one emesh packet sink among N sources,
// with a registered single-entry output stage that honours wait_in backpressure.
module emesh_stim_arbiter
  import emesh_arb_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int AW    = AW_DEF,
  parameter int PW    = pw(AW),
  parameter int BURST = BURST_DEF,
  parameter int SW    = $clog2(N)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N-1:0]    access_in,
  input  logic [N*PW-1:0] packet_in,
  output logic [N-1:0]    wait_out,
  output logic            access_out,
  output logic [PW-1:0]   packet_out,
  output logic [SW-1:0]   src_out,
  input  logic            wait_in
);

  localparam int CW = $clog2(BURST + 1);

  logic            access_q, access_d;
  logic [PW-1:0]   packet_q, packet_d;
  logic [SW-1:0]   src_q, src_d;
  logic [SW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic            load;
  logic            owner_eligible;
  logic [SW-1:0]   start;
  logic            gnt_valid;
  logic [SW-1:0]   gnt;

  assign load           = ~access_q | ~wait_in;
  assign owner_eligible = access_in[owner_q] & (cnt_q < CW'(BURST));
  assign start          = owner_eligible ? owner_q
                        : ((owner_q == SW'(N - 1)) ? '0 : owner_q + 1'b1);

  emesh_rr_pick #(.N(N), .SW(SW)) u_pick (
    .req       (access_in),
    .start     (start),
    .gnt_valid (gnt_valid),
    .gnt       (gnt)
  );

  for (genvar gi = 0; gi < N; gi++) begin : g_wait
    assign wait_out[gi] = access_in[gi] & ~(load & gnt_valid & (gnt == SW'(gi)));
  end

  // A lone requester that exhausted its burst wraps back to itself via the
  // new-owner path, restarting its count at 1 without a bubble.
  always_comb begin
    access_d = access_q;
    packet_d = packet_q;
    src_d    = src_q;
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    if (load) begin
      if (gnt_valid) begin
        access_d = 1'b1;
        packet_d = packet_in[gnt*PW +: PW];
        src_d    = gnt;
        if (owner_eligible) begin
          cnt_d = cnt_q + 1'b1;
        end else begin
          owner_d = gnt;
          cnt_d   = CW'(1);
        end
      end else begin
        access_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      access_q <= 1'b0;
      packet_q <= '0;
      src_q    <= '0;
      owner_q  <= SW'(N - 1);
      cnt_q    <= CW'(BURST);
    end else begin
      access_q <= access_d;
      packet_q <= packet_d;
      src_q    <= src_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
    end
  end

  assign access_out = access_q;
  assign packet_out = packet_q;
  assign src_out    = src_q;

endmodule

// File: tb/tb_emesh_stim_arbiter.sv
// Directed plus randomized bench for emesh_stim_arbiter against a grant-history reference model.
module tb_emesh_stim_arbiter;

  localparam int N     = 4;
  localparam int AW    = 32;
  localparam int PW    = 2 * AW + 40;
  localparam int BURST = 2;
  localparam int SW    = 2;

  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    access_in;
  logic [N*PW-1:0] packet_in;
  logic [N-1:0]    wait_out;
  logic            access_out;
  logic [PW-1:0]   packet_out;
  logic [SW-1:0]   src_out;
  logic            wait_in;

  int tests = 0;
  int fails = 0;

  // Reference model: who holds the burst, how many grants it has had, and the output register.
  int            m_owner;
  int            m_cnt;
  logic          m_acc;
  logic [PW-1:0] m_pkt;
  int            m_src;

  int            src_log[$];

  always #5 clk = ~clk;

  emesh_stim_arbiter #(.N(N), .AW(AW), .PW(PW), .BURST(BURST), .SW(SW)) dut (
    .clk        (clk),
    .reset      (reset),
    .access_in  (access_in),
    .packet_in  (packet_in),
    .wait_out   (wait_out),
    .access_out (access_out),
    .packet_out (packet_out),
    .src_out    (src_out),
    .wait_in    (wait_in)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [PW-1:0] rand_pkt();
    logic [PW-1:0] p = '0;
    for (int j = 0; j < (PW + 31) / 32; j++) p = (p << 32) | PW'($urandom);
    return p;
  endfunction

  function automatic int model_pick(input logic [N-1:0] acc);
    if (acc[m_owner] && m_cnt < BURST) return m_owner;
    for (int k = 1; k <= N; k++) begin
      if (acc[(m_owner + k) % N]) return (m_owner + k) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = N - 1;
    m_cnt   = BURST;
    m_acc   = 1'b0;
    m_pkt   = '0;
    m_src   = 0;
  endtask

  task automatic cycle(input logic [N-1:0] acc, input logic win, input logic rst);
    int            g;
    logic          load;
    logic [N-1:0]  exp_wait;
    logic [PW-1:0] pkts[N];
    access_in = acc;
    wait_in   = win;
    reset     = rst;
    for (int i = 0; i < N; i++) begin
      pkts[i] = rand_pkt();
      packet_in[i*PW +: PW] = pkts[i];
    end
    #1;
    load = !m_acc || !win;
    g    = model_pick(acc);
    for (int i = 0; i < N; i++) exp_wait[i] = acc[i] && !(load && g == i);
    check("wait_out", 128'(wait_out), 128'(exp_wait));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else if (load) begin
      if (g >= 0) begin
        if (g == m_owner && acc[m_owner] && m_cnt < BURST) begin
          m_cnt++;
        end else begin
          m_owner = g;
          m_cnt   = 1;
        end
        m_acc = 1'b1;
        m_pkt = pkts[g];
        m_src = g;
      end else begin
        m_acc = 1'b0;
      end
    end
    #1;
    check("access_out", 128'(access_out), 128'(m_acc));
    check("src_out", 128'(src_out), 128'(m_src));
    check("packet_out", 128'(packet_out), 128'(m_pkt));
    if (access_out) src_log.push_back(int'(src_out));
    $display("[TB] acc=%b win=%b rst=%b -> wait_out=%b access_out=%0d src_out=%0d",
             acc, win, rst, wait_out, access_out, src_out);
  endtask

  initial begin
    int exp1[9] = '{0, 0, 1, 1, 2, 2, 3, 3, 0};
    access_in = '0;
    packet_in = '0;
    wait_in   = 1'b0;
    reset     = 1'b1;
    model_reset();

    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b0000, 1'b0, 1'b1);
    check("reset_access_out", 128'(access_out), 128'(0));
    check("reset_packet_out", 128'(packet_out), 128'(0));
    check("reset_src_out", 128'(src_out), 128'(0));

    // Four-way stream with burst of two, then a three-cycle stall.
    src_log.delete();
    for (int c = 0; c < 9; c++) cycle(4'b1111, 1'b0, 1'b0);
    check("stream_len", 128'(src_log.size()), 128'(9));
    for (int c = 0; c < 9 && c < src_log.size(); c++)
      check("stream_order", 128'(src_log[c]), 128'(exp1[c]));
    for (int c = 0; c < 3; c++) cycle(4'b1111, 1'b1, 1'b0);
    for (int c = 0; c < 4; c++) cycle(4'b1111, 1'b0, 1'b0);

    // Requests stop: output valid drops, packet holds.
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b1, 1'b0);

    // Single requester streams without bubbles.
    cycle(4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 6; c++) cycle(4'b0100, 1'b0, 1'b0);
    check("single_src", 128'(src_out), 128'(2));

    // Source 1 drops after one grant; source 3 takes its burst.
    cycle(4'b0000, 1'b0, 1'b1);
    cycle(4'b1010, 1'b0, 1'b0);
    check("drop_first", 128'(src_out), 128'(1));
    for (int c = 0; c < 3; c++) cycle(4'b1000, 1'b0, 1'b0);

    // Reset while stalled with a valid output.
    cycle(4'b1111, 1'b0, 1'b0);
    cycle(4'b1111, 1'b1, 1'b0);
    cycle(4'b1111, 1'b1, 1'b1);
    check("reset_mid_access", 128'(access_out), 128'(0));
    cycle(4'b0110, 1'b0, 1'b0);
    check("after_reset_grant", 128'(src_out), 128'(1));

    for (int c = 0; c < 300; c++) begin
      cycle(N'($urandom), ($urandom_range(3, 0) == 0), ($urandom_range(49, 0) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
